// File: rtl/npu_pkg.sv
// Shared NPU definitions: channel index width, scheduler state encoding,
// scheduler parameter defaults and the channel-count clamp helper.
package npu_pkg;

   // Width of every channel index in the conv1 -> conv2 datapath
   localparam int CHAN_W      = 4;

   // Scheduler parameter defaults
   localparam int CHAN_DEF    = 10;
   localparam int TIMEOUT_DEF = 1023;
   localparam int TO_W_DEF    = 10;

   // Channel scheduler states
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_ACC   = 3'd4,
      S_FIN   = 3'd5
   } sched_state_t;

   // A requested channel count of zero or above the per-image maximum falls
   // back to the full per-image channel count.
   function automatic logic [CHAN_W-1:0] clamp_nchan(
      input logic [CHAN_W-1:0] cfg,
      input logic [CHAN_W-1:0] max_chan
   );
      logic [CHAN_W-1:0] res;
      if ((cfg == {CHAN_W{1'b0}}) || (cfg > max_chan)) begin
         res = max_chan;
      end else begin
         res = cfg;
      end
      return res;
   endfunction

endpackage

// File: rtl/conv_chan_sched.sv
// Channel scheduler for the conv1 -> conv2 datapath. Issues one trigger per
// output channel, waits for the tagged stage-2 result, strobes the channel-sum
// buffer and reports busy / done / sticky error to the NPU sequencer.
module conv_chan_sched
   import npu_pkg::*;
#(
   parameter int CHAN    = CHAN_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TO_W    = TO_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CHAN_W-1:0] cfg_nchan,
   output logic              conv_trig,
   output logic [CHAN_W-1:0] conv_chan,
   input  logic              res_valid,
   input  logic [CHAN_W-1:0] res_chan,
   output logic              acc_clr,
   output logic              acc_en,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [CHAN_W-1:0] CHAN_MAX  = CHAN_W'(CHAN);
   localparam logic [CHAN_W-1:0] CHAN_ZERO = CHAN_W'(0);
   localparam logic [CHAN_W-1:0] CHAN_ONE  = CHAN_W'(1);
   localparam logic [TO_W-1:0]   TO_ZERO   = TO_W'(0);
   localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
   // Counter value in the last WAIT cycle allowed before the timeout fires;
   // the counter reaches TIMEOUT on the edge that ends that cycle.
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

   sched_state_t      state_q,     state_d;
   logic [CHAN_W-1:0] nchan_q,     nchan_d;
   logic [CHAN_W-1:0] conv_chan_q, conv_chan_d;
   logic [TO_W-1:0]   cnt_q,       cnt_d;
   logic              err_q,       err_d;
   logic              conv_trig_q, conv_trig_d;
   logic              acc_clr_q,   acc_clr_d;
   logic              acc_en_q,    acc_en_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;

   // Next-state, counters and sticky error for the scheduler FSM
   always_comb begin
      state_d     = state_q;
      nchan_d     = nchan_q;
      conv_chan_d = conv_chan_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               nchan_d     = clamp_nchan(cfg_nchan, CHAN_MAX);
               err_d       = 1'b0;
               conv_chan_d = CHAN_ZERO;
               state_d     = S_CLR;
            end else begin
               state_d     = S_IDLE;
            end
         end
         S_CLR: begin
            conv_chan_d = CHAN_ZERO;
            state_d     = S_ISSUE;
         end
         S_ISSUE: begin
            cnt_d   = TO_ZERO;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + TO_ONE;
            // A result arriving in the final allowed cycle still wins over the timeout
            if (res_valid) begin
               if (res_chan == conv_chan_q) begin
                  state_d = S_ACC;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_ACC: begin
            if (conv_chan_q == (nchan_q - CHAN_ONE)) begin
               state_d = S_FIN;
            end else begin
               conv_chan_d = conv_chan_q + CHAN_ONE;
               state_d     = S_ISSUE;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Strobes are decoded from the next state so the registered copies line up
   // exactly with the state they belong to
   always_comb begin
      conv_trig_d = 1'b0;
      acc_clr_d   = 1'b0;
      acc_en_d    = 1'b0;
      done_d      = 1'b0;
      busy_d      = 1'b1;
      case (state_d)
         S_IDLE:  busy_d      = 1'b0;
         S_CLR:   acc_clr_d   = 1'b1;
         S_ISSUE: conv_trig_d = 1'b1;
         S_WAIT:  busy_d      = 1'b1;
         S_ACC:   acc_en_d    = 1'b1;
         S_FIN:   done_d      = 1'b1;
         default: busy_d      = 1'b0;
      endcase
   end

   // State, counters and registered outputs with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         nchan_q     <= CHAN_MAX;
         conv_chan_q <= CHAN_ZERO;
         cnt_q       <= TO_ZERO;
         err_q       <= 1'b0;
         conv_trig_q <= 1'b0;
         acc_clr_q   <= 1'b0;
         acc_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         nchan_q     <= nchan_d;
         conv_chan_q <= conv_chan_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         conv_trig_q <= conv_trig_d;
         acc_clr_q   <= acc_clr_d;
         acc_en_q    <= acc_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign conv_trig = conv_trig_q;
   assign conv_chan = conv_chan_q;
   assign acc_clr   = acc_clr_q;
   assign acc_en    = acc_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
